// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester and FIFO-side signals of the write arbiter.
//   req           : per-requester "word offered" flags (4)
//   req_data      : packed requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full_in       : FIFO write-side full flag
//   data_in       : word presented to the FIFO write port
//   enable_in     : FIFO write enable
//   grant         : registered one-hot (or zero) current owner
//   ack           : one-hot, requester's word is written this cycle
//   busy          : any grant bit set
//   words_written : total words written (wrapping)
//   stall_cycles  : cycles the owner was blocked by full_in (saturating)
// slave modport is the arbiter side; master is the requester/FIFO side.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   logic [3:0]              req;
   logic [4*DATA_WIDTH-1:0] req_data;
   logic                    full_in;
   logic [DATA_WIDTH-1:0]   data_in;
   logic                    enable_in;
   logic [3:0]              grant;
   logic [3:0]              ack;
   logic                    busy;
   logic [15:0]             words_written;
   logic [15:0]             stall_cycles;

   modport master (
      output req, req_data, full_in,
      input  data_in, enable_in, grant, ack, busy, words_written, stall_cycles
   );

   modport slave (
      input  req, req_data, full_in,
      output data_in, enable_in, grant, ack, busy, words_written, stall_cycles
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter granting one of four requesters write access to a FIFO
// for bursts of up to MAX_BURST words. A word is written whenever the owner
// offers one and the FIFO is not full; ownership passes on when the owner
// withdraws its request or completes a full burst.
// Ports:
//   clk_in : write-side clock, all state changes on its rising edge
//   reset  : synchronous, active-high reset
//   bus    : fifo_wr_arbiter_if.slave (requests, data, FIFO handshake, stats)
// Parameters:
//   DATA_WIDTH : requester word width
//   MAX_BURST  : maximum words per grant (1..255)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 8
) (
   input  logic               clk_in,
   input  logic               reset,
   fifo_wr_arbiter_if.slave   bus
);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   localparam logic [7:0] LAST_BCNT = 8'(MAX_BURST - 1);

   state_t      state_reg, state_next;
   logic [3:0]  grant_reg, grant_next;
   logic [1:0]  ptr_reg, ptr_next;
   logic [7:0]  bcnt_reg, bcnt_next;
   logic [15:0] words_reg, words_next;
   logic [15:0] stall_reg, stall_next;

   logic [3:0]            write_term;
   logic                  write_any;
   logic [1:0]            owner_idx;
   logic                  owner_req;
   logic [DATA_WIDTH-1:0] slice_masked [4];

   // First set request bit found searching start, start+1, ... modulo 4.
   function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
      logic [3:0] pick;
      logic [1:0] idx;
      pick = '0;
      for (int k = 0; k < 4; k++) begin
         idx = start + 2'(k);
         if (pick == 4'b0 && r[idx]) begin
            pick[idx] = 1'b1;
         end
      end
      return pick;
   endfunction

   // Write qualification and data slicing per requester; reset gates the
   // write term so nothing reaches the FIFO while reset is held.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_req
         assign write_term[gi]   = grant_reg[gi] & bus.req[gi] & ~bus.full_in & ~reset;
         assign slice_masked[gi] = grant_reg[gi] ? bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                                 : '0;
      end
   endgenerate

   assign write_any = |write_term;

   always_comb begin
      owner_idx = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (grant_reg[k]) begin
            owner_idx = 2'(k);
         end
      end
   end

   assign owner_req = bus.req[owner_idx];

   // State register
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_reg <= IDLE;
         grant_reg <= '0;
         ptr_reg   <= '0;
         bcnt_reg  <= '0;
         words_reg <= '0;
         stall_reg <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         ptr_reg   <= ptr_next;
         bcnt_reg  <= bcnt_next;
         words_reg <= words_next;
         stall_reg <= stall_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      ptr_next   = ptr_reg;
      bcnt_next  = bcnt_reg;
      words_next = words_reg;
      stall_next = stall_reg;
      case (state_reg)
         IDLE: begin
            if (bus.req != 4'b0) begin
               grant_next = rr_pick(bus.req, ptr_reg);
               bcnt_next  = '0;
               state_next = OWN;
            end
         end
         OWN: begin
            if (write_any) begin
               words_next = words_reg + 16'd1;
            end
            if (owner_req && bus.full_in && stall_reg != 16'hFFFF) begin
               stall_next = stall_reg + 16'd1;
            end
            // Release: the owner is searched last, so it is re-granted only
            // when nobody else is requesting.
            if (!owner_req || (write_any && bcnt_reg == LAST_BCNT)) begin
               ptr_next   = owner_idx + 2'd1;
               bcnt_next  = '0;
               grant_next = rr_pick(bus.req, owner_idx + 2'd1);
               state_next = (bus.req == 4'b0) ? IDLE : OWN;
            end else if (write_any) begin
               bcnt_next = bcnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      bus.ack           = write_term;
      bus.enable_in     = write_any;
      bus.grant         = grant_reg;
      bus.busy          = |grant_reg;
      bus.words_written = words_reg;
      bus.stall_cycles  = stall_reg;
      bus.data_in       = '0;
      for (int k = 0; k < 4; k++) begin
         bus.data_in = bus.data_in | slice_masked[k];
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter. Two instances: dut4 (MAX_BURST=4)
// carries the vector table and most corner sequences, dut8 (MAX_BURST=8)
// covers the single-requester streaming case and the counter wrap.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   logic clk_in;
   logic reset;

   int n_checks;
   int n_errors;

   fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus4 ();
   fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus8 ();

   fifo_wr_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut4 (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus4)
   );

   fifo_wr_arbiter #(.DATA_WIDTH(8), .MAX_BURST(8)) dut8 (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus8)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [3:0]  req;
      logic        full;
      logic [3:0]  exp_grant;
      logic [3:0]  exp_ack;
      logic [15:0] exp_ww;
      logic [15:0] exp_stall;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(input logic [3:0] r, input logic f, input logic [3:0] g,
                               input logic [3:0] a, input logic [15:0] w, input logic [15:0] s);
      vec_t v;
      v.req = r; v.full = f; v.exp_grant = g; v.exp_ack = a; v.exp_ww = w; v.exp_stall = s;
      return v;
   endfunction

   // Requester i always offers 8'hA0+i.
   function automatic logic [7:0] exp_data(input logic [3:0] g);
      case (g)
         4'b0001: return 8'hA0;
         4'b0010: return 8'hA1;
         4'b0100: return 8'hA2;
         4'b1000: return 8'hA3;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_val);
      n_checks++;
      if (act !== req_val) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req_val);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] g, input logic [3:0] a,
                       input logic [15:0] w);
      chk({tag, " grant4"}, 32'(bus4.grant), 32'(g));
      chk({tag, " ack4"}, 32'(bus4.ack), 32'(a));
      chk({tag, " en4"}, 32'(bus4.enable_in), 32'(|a));
      chk({tag, " data4"}, 32'(bus4.data_in), 32'(exp_data(g)));
      chk({tag, " busy4"}, 32'(bus4.busy), 32'(|g));
      chk({tag, " ww4"}, 32'(bus4.words_written), 32'(w));
   endtask

   task automatic chk8(input string tag, input logic [3:0] g, input logic [3:0] a,
                       input logic [15:0] w);
      chk({tag, " grant8"}, 32'(bus8.grant), 32'(g));
      chk({tag, " ack8"}, 32'(bus8.ack), 32'(a));
      chk({tag, " en8"}, 32'(bus8.enable_in), 32'(|a));
      chk({tag, " data8"}, 32'(bus8.data_in), 32'(exp_data(g)));
      chk({tag, " ww8"}, 32'(bus8.words_written), 32'(w));
   endtask

   task automatic drive(input logic [3:0] r, input logic f);
      bus4.req = r; bus4.full_in = f;
      bus8.req = r; bus8.full_in = f;
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(4'b0000, 1'b0);
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus4.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      bus8.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      drive(4'b0000, 1'b0);

      // ---- Vector table: all four requesting with MAX_BURST=4, then stall,
      //      owner drop to IDLE and pointer-based re-arbitration.
      tbl[0] = mk(4'hF, 1'b0, 4'b0000, 4'b0000, 16'd0, 16'd0);
      for (int k = 0; k < 16; k++) begin
         tbl[k+1] = mk(4'hF, 1'b0, 4'(1 << (k / 4)), 4'(1 << (k / 4)), 16'(k), 16'd0);
      end
      tbl[17] = mk(4'hF,    1'b0, 4'b0001, 4'b0001, 16'd16, 16'd0);
      tbl[18] = mk(4'hF,    1'b1, 4'b0001, 4'b0000, 16'd17, 16'd0);
      tbl[19] = mk(4'b0001, 1'b1, 4'b0001, 4'b0000, 16'd17, 16'd1);
      tbl[20] = mk(4'b0000, 1'b0, 4'b0001, 4'b0000, 16'd17, 16'd2);
      tbl[21] = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 16'd17, 16'd2);
      tbl[22] = mk(4'b0011, 1'b0, 4'b0000, 4'b0000, 16'd17, 16'd2);
      tbl[23] = mk(4'b0011, 1'b0, 4'b0010, 4'b0010, 16'd17, 16'd2);

      do_reset();
      chk("reset grant4", 32'(bus4.grant), 32'd0);
      chk("reset ww4", 32'(bus4.words_written), 32'd0);
      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].req, tbl[i].full);
         #1;
         $display("vec %0d req=%b full=%b grant=%b ack=%b ww=%0d stall=%0d", i, tbl[i].req,
                  tbl[i].full, bus4.grant, bus4.ack, bus4.words_written, bus4.stall_cycles);
         chk4($sformatf("vec%0d", i), tbl[i].exp_grant, tbl[i].exp_ack, tbl[i].exp_ww);
         chk($sformatf("vec%0d stall4", i), 32'(bus4.stall_cycles), 32'(tbl[i].exp_stall));
         step();
      end

      // ---- Single requester streaming, MAX_BURST=8: back-to-back bursts.
      do_reset();
      drive(4'b0001, 1'b0);
      #1;
      chk8("single c0", 4'b0000, 4'b0000, 16'd0);
      step();
      for (int k = 0; k < 20; k++) begin
         chk8($sformatf("single c%0d", k + 1), 4'b0001, 4'b0001, 16'(k));
         step();
      end
      $display("single-requester stream: ww=%0d", bus8.words_written);

      // ---- Owner 2 stalled by full for 5 cycles; burst count must be held.
      do_reset();
      drive(4'b0100, 1'b0);
      #1;
      chk4("stall c0", 4'b0000, 4'b0000, 16'd0);
      step();
      chk4("stall c1", 4'b0100, 4'b0100, 16'd0);
      step();
      drive(4'b0101, 1'b0);
      #1;
      chk4("stall c2", 4'b0100, 4'b0100, 16'd1);
      step();
      drive(4'b0101, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk4($sformatf("stall full%0d", k), 4'b0100, 4'b0000, 16'd2);
         chk($sformatf("stall cnt%0d", k), 32'(bus4.stall_cycles), 32'(k));
         step();
      end
      drive(4'b0101, 1'b0);
      #1;
      chk4("stall resume0", 4'b0100, 4'b0100, 16'd2);
      chk("stall total", 32'(bus4.stall_cycles), 32'd5);
      step();
      chk4("stall resume1", 4'b0100, 4'b0100, 16'd3);
      step();
      chk4("stall handoff", 4'b0001, 4'b0001, 16'd4);
      $display("stall sequence: stall=%0d grant=%b", bus4.stall_cycles, bus4.grant);

      // ---- Owner 1 drops after 3 words with requester 3 pending.
      do_reset();
      drive(4'b0010, 1'b0);
      step();
      for (int k = 0; k < 3; k++) begin
         chk4($sformatf("drop w%0d", k), 4'b0010, 4'b0010, 16'(k));
         step();
      end
      drive(4'b1000, 1'b0);
      #1;
      chk4("drop edge", 4'b0010, 4'b0000, 16'd3);
      step();
      chk4("drop moved", 4'b1000, 4'b1000, 16'd3);
      $display("drop handoff: grant=%b", bus4.grant);

      // ---- Owner 1 drops to IDLE; the next search starts at requester 2.
      do_reset();
      drive(4'b0010, 1'b0);
      step();
      chk4("ptr own", 4'b0010, 4'b0010, 16'd0);
      step();
      drive(4'b0000, 1'b0);
      #1;
      chk4("ptr release", 4'b0010, 4'b0000, 16'd1);
      step();
      drive(4'b1001, 1'b0);
      #1;
      chk4("ptr idle", 4'b0000, 4'b0000, 16'd1);
      step();
      chk4("ptr regrant", 4'b1000, 4'b1000, 16'd1);
      $display("idle search from ptr: grant=%b", bus4.grant);

      // ---- Reset mid-burst after 10 words.
      do_reset();
      drive(4'hF, 1'b0);
      step();
      repeat (10) step();
      chk4("rst pre", 4'b0100, 4'b0100, 16'd10);
      reset = 1'b1;
      #1;
      chk("rst ack comb", 32'(bus4.ack), 32'd0);
      chk("rst en comb", 32'(bus4.enable_in), 32'd0);
      step();
      chk4("rst edge", 4'b0000, 4'b0000, 16'd0);
      chk("rst stall", 32'(bus4.stall_cycles), 32'd0);
      reset = 1'b0;
      drive(4'b1001, 1'b0);
      #1;
      chk4("rst post0", 4'b0000, 4'b0000, 16'd0);
      step();
      chk4("rst post1", 4'b0001, 4'b0001, 16'd0);
      $display("reset mid-burst: post-reset grant=%b", bus4.grant);

      // ---- words_written wrap on dut8, stall_cycles saturation on dut4.
      do_reset();
      bus8.req = 4'b0001; bus8.full_in = 1'b0;
      bus4.req = 4'b0001; bus4.full_in = 1'b1;
      step();
      chk("wrap start ww8", 32'(bus8.words_written), 32'd0);
      chk("sat start stall4", 32'(bus4.stall_cycles), 32'd0);
      repeat (65535) step();
      chk("wrap max ww8", 32'(bus8.words_written), 32'h0000FFFF);
      chk("sat max stall4", 32'(bus4.stall_cycles), 32'h0000FFFF);
      step();
      chk("wrap zero ww8", 32'(bus8.words_written), 32'd0);
      chk("wrap ack8", 32'(bus8.ack), 32'b0001);
      chk("sat hold stall4", 32'(bus4.stall_cycles), 32'h0000FFFF);
      chk("sat grant4", 32'(bus4.grant), 32'b0001);
      $display("wrap/saturate: ww8=%0h stall4=%0h", bus8.words_written, bus4.stall_cycles);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
